capture_reader_of_verifla: RTL and testbench

- Readout end of the capture memory written by the logic-analyzer monitor.
- On the monitor's sc_run request, acknowledges it, then walks capture memory port B from the last address down to address 0. Each word is serialized as bytes, MSB byte first, over a valid/ready byte stream into the UART transmitter.
- Pulses sc_done when the last byte is accepted, so the monitor can return to idle.

---
 rtl/verifla_pkg.sv | 24 ++
 rtl/capture_reader_of_verifla_if.sv | 31 +++
 rtl/verifla_word_serializer.sv | 43 ++++
 rtl/capture_reader_of_verifla.sv | 136 +++++++++++++
 tb/tb_capture_reader_of_verifla.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/verifla_pkg.sv
// verifla_pkg: capture sizes shared with the monitor, word-byte helper
// and readout states (ST_CKSUM only with VERIFLA_READOUT_CHECKSUM_EN).
package verifla_pkg;

   localparam int MEM_ADDRESS_BITS_DEF = 8;
   localparam int MEM_WORDLEN_BITS_DEF = 24;

   function automatic int word_bytes(input int bits);
      return (bits + 7) / 8;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACK,
      ST_RD_WAIT,
      ST_LOAD,
      ST_SEND,
`ifdef VERIFLA_READOUT_CHECKSUM_EN
      ST_CKSUM,
`endif
      ST_DONE
   } state_t;

endpackage

// File: rtl/capture_reader_of_verifla_if.sv
// Readout bus: monitor handshake, capture memory port B and the
// byte stream towards the UART transmitter.
interface capture_reader_of_verifla_if
   import verifla_pkg::*;
#(
   parameter int MEM_ADDRESS_BITS = MEM_ADDRESS_BITS_DEF,
   parameter int MEM_WORDLEN_BITS = MEM_WORDLEN_BITS_DEF
);
   logic                        sc_run;
   logic                        ack_sc_run;
   logic                        sc_done;
   logic                        busy;
   logic [MEM_ADDRESS_BITS-1:0] mem_port_B_address;
   logic [MEM_WORDLEN_BITS-1:0] mem_port_B_dout;
   logic [7:0]                  tx_data;
   logic                        tx_valid;
   logic                        tx_ready;

   modport master (
      input  sc_run, mem_port_B_dout, tx_ready,
      output ack_sc_run, sc_done, busy,
      output mem_port_B_address, tx_data, tx_valid
   );

   modport slave (
      output sc_run, mem_port_B_dout, tx_ready,
      input  ack_sc_run, sc_done, busy,
      input  mem_port_B_address, tx_data, tx_valid
   );

endinterface

// File: rtl/verifla_word_serializer.sv
// Shifts a loaded word out MSB byte first on a valid/ready stream;
// last_acc flags the handshake of the final byte.
module verifla_word_serializer #(
   parameter int WORD_BYTES = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [WORD_BYTES*8-1:0] word,
   input  logic [2:0]              last_idx,
   input  logic                    tx_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   output logic                    last_acc
);
   logic [WORD_BYTES*8-1:0] sr;
   logic [2:0]              cnt;
   logic                    vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
         vld <= 1'b0;
      end else if (load) begin
         sr  <= word;
         cnt <= last_idx;
         vld <= 1'b1;
      end else if (vld && tx_ready) begin
         if (cnt != 3'd0) begin
            sr  <= sr << 8;
            cnt <= cnt - 3'd1;
         end else begin
            vld <= 1'b0;
         end
      end
   end

   assign tx_data  = sr[WORD_BYTES*8-1 -: 8];
   assign tx_valid = vld;
   assign last_acc = vld && tx_ready && (cnt == 3'd0);

endmodule

// File: rtl/capture_reader_of_verifla.sv
// Capture readout: walks memory from MEM_LAST_ADDR down to 0 and streams
// each word MSB byte first; VERIFLA_READOUT_CHECKSUM_EN appends an XOR byte.
module capture_reader_of_verifla
   import verifla_pkg::*;
#(
   parameter int MEM_ADDRESS_BITS = MEM_ADDRESS_BITS_DEF,
   parameter int MEM_WORDLEN_BITS = MEM_WORDLEN_BITS_DEF,
   parameter int MEM_LAST_ADDR    = 255,
   parameter int WORD_BYTES       = word_bytes(MEM_WORDLEN_BITS)
) (
   input logic                          clk,
   input logic                          rst,
   capture_reader_of_verifla_if.master bus
);
   localparam int WBITS = WORD_BYTES * 8;
   localparam logic [MEM_ADDRESS_BITS-1:0] LAST =
      MEM_ADDRESS_BITS'(MEM_LAST_ADDR);
   localparam logic [MEM_ADDRESS_BITS-1:0] ONE =
      MEM_ADDRESS_BITS'(1);

   state_t                      state_q, state_d;
   logic [MEM_ADDRESS_BITS-1:0] addr_q, addr_d;
   logic                        ack_q, ack_d;
   logic                        done_q, done_d;
   logic                        busy_q, busy_d;
   logic                        ser_load, ser_last, ser_valid;
   logic [WBITS-1:0]            ser_word;
   logic [2:0]                  ser_last_idx;
   logic [7:0]                  ser_data;
`ifdef VERIFLA_READOUT_CHECKSUM_EN
   logic [7:0]                  cksum_q, cksum_d;
`endif

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      ser_load     = 1'b0;
      ser_word     = '0;
      ser_word[MEM_WORDLEN_BITS-1:0] = bus.mem_port_B_dout;
      ser_last_idx = 3'(WORD_BYTES - 1);
`ifdef VERIFLA_READOUT_CHECKSUM_EN
      cksum_d      = cksum_q;
`endif
      unique case (state_q)
         ST_IDLE:    if (bus.sc_run) state_d = ST_ACK;
         ST_ACK: begin
            addr_d  = LAST;
            state_d = ST_RD_WAIT;
`ifdef VERIFLA_READOUT_CHECKSUM_EN
            cksum_d = '0;
`endif
         end
         ST_RD_WAIT: state_d = ST_LOAD;
         ST_LOAD: begin
            ser_load = 1'b1;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
`ifdef VERIFLA_READOUT_CHECKSUM_EN
            if (ser_valid && bus.tx_ready)
               cksum_d = cksum_q ^ ser_data;
`endif
            if (ser_last) begin
               if (addr_q == '0) begin
`ifdef VERIFLA_READOUT_CHECKSUM_EN
                  // checksum byte follows the last data byte directly
                  ser_load     = 1'b1;
                  ser_word     = '0;
                  ser_word[WBITS-1 -: 8] = cksum_q ^ ser_data;
                  ser_last_idx = 3'd0;
                  state_d      = ST_CKSUM;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  addr_d  = addr_q - ONE;
                  state_d = ST_RD_WAIT;
               end
            end
         end
`ifdef VERIFLA_READOUT_CHECKSUM_EN
         ST_CKSUM:   if (ser_last) state_d = ST_DONE;
`endif
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      ack_d  = (state_d == ST_ACK);
      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= LAST;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

`ifdef VERIFLA_READOUT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) cksum_q <= '0;
      else     cksum_q <= cksum_d;
   end
`endif

   verifla_word_serializer #(
      .WORD_BYTES(WORD_BYTES)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .word     (ser_word),
      .last_idx (ser_last_idx),
      .tx_ready (bus.tx_ready),
      .tx_data  (ser_data),
      .tx_valid (ser_valid),
      .last_acc (ser_last)
   );

   assign bus.ack_sc_run         = ack_q;
   assign bus.sc_done            = done_q;
   assign bus.busy               = busy_q;
   assign bus.mem_port_B_address = addr_q;
   assign bus.tx_data            = ser_data;
   assign bus.tx_valid           = ser_valid;

endmodule

// File: tb/tb_capture_reader_of_verifla.sv
// Bench: random memory images and tx_ready backpressure, byte stream
// compared with a model built directly from the memory image.
module tb_capture_reader_of_verifla;
   localparam int AW   = 8;
   localparam int WA   = 24;
   localparam int LA   = 3;
   localparam int WBA  = (WA + 7) / 8;
   localparam int WBW  = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] got[$];
   logic [7:0] exp[$];
   int n_ack, n_done, n_unstable, cyc;

   logic [WA-1:0]  mem_a [0:255];
   logic [WBW-1:0] mem_b [0:255];

   capture_reader_of_verifla_if #(
      .MEM_ADDRESS_BITS(AW), .MEM_WORDLEN_BITS(WA)) a_if();
   capture_reader_of_verifla_if #(
      .MEM_ADDRESS_BITS(AW), .MEM_WORDLEN_BITS(WBW)) b_if();

   capture_reader_of_verifla #(
      .MEM_ADDRESS_BITS(AW), .MEM_WORDLEN_BITS(WA),
      .MEM_LAST_ADDR(LA)
   ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

   capture_reader_of_verifla #(
      .MEM_ADDRESS_BITS(AW), .MEM_WORDLEN_BITS(WBW),
      .MEM_LAST_ADDR(0)
   ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      a_if.mem_port_B_dout <= mem_a[a_if.mem_port_B_address];
      b_if.mem_port_B_dout <= mem_b[b_if.mem_port_B_address];
   end

   task automatic model_a();
      logic [7:0] x, bt;
      exp.delete();
      x = 8'h00;
      for (int a = LA; a >= 0; a--)
         for (int b = WBA - 1; b >= 0; b--) begin
            bt = 8'(32'(mem_a[a]) >> (8 * b));
            exp.push_back(bt);
            x ^= bt;
         end
`ifdef VERIFLA_READOUT_CHECKSUM_EN
      exp.push_back(x);
`endif
   endtask

   task automatic set_basic_mem();
      mem_a[3] = 24'h112233;
      mem_a[2] = 24'h445566;
      mem_a[1] = 24'h778899;
      mem_a[0] = 24'hAABBCC;
   endtask

   // runs DUT A until sc_done, recording accepted bytes
   task automatic collect_a(input int pct, input bit drop_on_ack,
                            input int glitch, input int budget,
                            output bit timeout);
      bit         pv;
      logic [7:0] pd;
      got.delete();
      n_ack = 0; n_done = 0; n_unstable = 0; cyc = 0;
      timeout = 1'b1; pv = 1'b0; pd = 8'h00;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (pv && (a_if.tx_valid !== 1'b1 || a_if.tx_data !== pd))
            n_unstable++;
         if (c == glitch) a_if.sc_run = 1'b0;
         if (c == glitch + 1) a_if.sc_run = 1'b1;
         if (a_if.ack_sc_run === 1'b1) begin
            n_ack++;
            if (drop_on_ack) a_if.sc_run = 1'b0;
         end
         if (a_if.sc_done === 1'b1) begin
            n_done++;
            cyc = c + 1;
            timeout = 1'b0;
            break;
         end
         a_if.tx_ready = ($urandom_range(99) < pct);
         if (a_if.tx_valid && a_if.tx_ready) got.push_back(a_if.tx_data);
         pv = a_if.tx_valid && !a_if.tx_ready;
         pd = a_if.tx_data;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks += 7;
      if (a_if.ack_sc_run !== 1'b0) begin n_fail++;
         $display("FAIL reset_ack got %b want 0", a_if.ack_sc_run); end
      if (a_if.sc_done !== 1'b0) begin n_fail++;
         $display("FAIL reset_done got %b want 0", a_if.sc_done); end
      if (a_if.tx_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_valid got %b want 0", a_if.tx_valid); end
      if (a_if.tx_data !== 8'h00) begin n_fail++;
         $display("FAIL reset_data got %h want 00", a_if.tx_data); end
      if (a_if.mem_port_B_address !== 8'(LA)) begin n_fail++;
         $display("FAIL reset_addr got %h want %h",
                  a_if.mem_port_B_address, 8'(LA)); end
      if (a_if.busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_busy got %b want 0", a_if.busy); end
      if (b_if.mem_port_B_address !== 8'h00) begin n_fail++;
         $display("FAIL reset_addr_b got %h want 00",
                  b_if.mem_port_B_address); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bit to;
      int want_cyc;
      set_basic_mem();
      model_a();
      a_if.sc_run = 1'b1;
      a_if.tx_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (a_if.ack_sc_run !== 1'b1) begin n_fail++;
         $display("FAIL basic_ack got %b want 1", a_if.ack_sc_run); end
      a_if.sc_run = 1'b0;
      collect_a(100, 1'b1, -10, 500, to);
      n_checks += 5;
      if (to) begin n_fail++;
         $display("FAIL basic_timeout got 1 want 0"); end
      if (n_ack != 0) begin n_fail++;
         $display("FAIL basic_extra_ack got %0d want 0", n_ack); end
      if (got.size() != exp.size()) begin n_fail++;
         $display("FAIL basic_count got %0d want %0d",
                  got.size(), exp.size()); end
      want_cyc = (LA + 1) * (2 + WBA) + 1;
`ifdef VERIFLA_READOUT_CHECKSUM_EN
      want_cyc += 1;
`endif
      if (cyc != want_cyc) begin n_fail++;
         $display("FAIL basic_cycles got %0d want %0d", cyc, want_cyc); end
      if (got.size() < 1 || got[0] !== 8'h11) begin n_fail++;
         $display("FAIL basic_first got %h want 11",
                  got.size() ? got[0] : 8'hxx); end
      foreach (exp[i]) begin
         n_checks++;
         if (got[i] !== exp[i]) begin n_fail++;
            $display("FAIL basic_byte%0d got %h want %h",
                     i, got[i], exp[i]); end
      end
      @(negedge clk);
      n_checks += 2;
      if (a_if.busy !== 1'b0) begin n_fail++;
         $display("FAIL basic_busy_after got %b want 0", a_if.busy); end
      if (a_if.sc_done !== 1'b0) begin n_fail++;
         $display("FAIL basic_done_width got %b want 0", a_if.sc_done); end
   endtask

   task automatic test_backpressure();
      bit to;
      int pct;
      for (int r = 0; r < 3; r++) begin
         if (r == 0) begin
            set_basic_mem();
            pct = 30;
         end else begin
            for (int a = 0; a <= LA; a++) mem_a[a] = 24'($urandom);
            pct = $urandom_range(80, 20);
         end
         model_a();
         @(negedge clk);
         a_if.sc_run = 1'b1;
         collect_a(pct, 1'b1, -10, 3000, to);
         n_checks += 5;
         if (to) begin n_fail++;
            $display("FAIL bp%0d_timeout got 1 want 0", r); end
         if (n_ack != 1) begin n_fail++;
            $display("FAIL bp%0d_acks got %0d want 1", r, n_ack); end
         if (n_done != 1) begin n_fail++;
            $display("FAIL bp%0d_done got %0d want 1", r, n_done); end
         if (n_unstable != 0) begin n_fail++;
            $display("FAIL bp%0d_stable got %0d want 0", r, n_unstable); end
         if (got.size() != exp.size()) begin n_fail++;
            $display("FAIL bp%0d_count got %0d want %0d",
                     r, got.size(), exp.size()); end
         foreach (exp[i]) begin
            n_checks++;
            if (got[i] !== exp[i]) begin n_fail++;
               $display("FAIL bp%0d_byte%0d got %h want %h",
                        r, i, got[i], exp[i]); end
         end
      end
   endtask

   task automatic test_sc_run_hold();
      bit to;
      int late_acks;
      for (int a = 0; a <= LA; a++) mem_a[a] = 24'($urandom);
      model_a();
      @(negedge clk);
      a_if.sc_run = 1'b1;
      collect_a(60, 1'b0, 7, 3000, to);
      n_checks += 3;
      if (to) begin n_fail++;
         $display("FAIL hold_timeout got 1 want 0"); end
      if (n_ack != 1) begin n_fail++;
         $display("FAIL hold_acks got %0d want 1", n_ack); end
      if (got.size() != exp.size()) begin n_fail++;
         $display("FAIL hold_count got %0d want %0d",
                  got.size(), exp.size()); end
      @(negedge clk);
      n_checks++;
      if (a_if.ack_sc_run !== 1'b0) begin n_fail++;
         $display("FAIL hold_idle_ack got %b want 0", a_if.ack_sc_run); end
      @(negedge clk);
      n_checks++;
      if (a_if.ack_sc_run !== 1'b1) begin n_fail++;
         $display("FAIL hold_rerun_ack got %b want 1", a_if.ack_sc_run); end
      a_if.sc_run = 1'b0;
      collect_a(100, 1'b1, -10, 500, to);
      n_checks += 2;
      if (to || n_done != 1) begin n_fail++;
         $display("FAIL hold_run2_done got %0d want 1", n_done); end
      if (got.size() != exp.size()) begin n_fail++;
         $display("FAIL hold_run2_count got %0d want %0d",
                  got.size(), exp.size()); end
      foreach (exp[i]) begin
         n_checks++;
         if (got[i] !== exp[i]) begin n_fail++;
            $display("FAIL hold_run2_byte%0d got %h want %h",
                     i, got[i], exp[i]); end
      end
      late_acks = 0;
      repeat (10) begin
         @(negedge clk);
         if (a_if.ack_sc_run === 1'b1) late_acks++;
      end
      n_checks++;
      if (late_acks != 0) begin n_fail++;
         $display("FAIL hold_no_rerun got %0d want 0", late_acks); end
   endtask

   task automatic test_reset_mid();
      bit to;
      int n, bad;
      set_basic_mem();
      model_a();
      @(negedge clk);
      a_if.sc_run = 1'b1;
      a_if.tx_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (a_if.ack_sc_run === 1'b1) a_if.sc_run = 1'b0;
         if (a_if.tx_valid && a_if.tx_ready) n++;
         if (n == 5) break;
      end
      n_checks++;
      if (n != 5) begin n_fail++;
         $display("FAIL rstmid_reach got %0d want 5", n); end
      @(negedge clk);
      rst = 1'b1;
      a_if.tx_ready = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (a_if.tx_valid !== 1'b0) begin n_fail++;
         $display("FAIL rstmid_valid got %b want 0", a_if.tx_valid); end
      if (a_if.busy !== 1'b0) begin n_fail++;
         $display("FAIL rstmid_busy got %b want 0", a_if.busy); end
      if (a_if.sc_done !== 1'b0) begin n_fail++;
         $display("FAIL rstmid_done got %b want 0", a_if.sc_done); end
      rst = 1'b0;
      a_if.tx_ready = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (a_if.sc_done === 1'b1 || a_if.tx_valid === 1'b1) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++;
         $display("FAIL rstmid_quiet got %0d want 0", bad); end
      a_if.sc_run = 1'b1;
      collect_a(100, 1'b1, -10, 500, to);
      n_checks += 3;
      if (to || n_done != 1) begin n_fail++;
         $display("FAIL rstmid_rerun_done got %0d want 1", n_done); end
      if (got.size() < 1 || got[0] !== 8'h11) begin n_fail++;
         $display("FAIL rstmid_first got %h want 11",
                  got.size() ? got[0] : 8'hxx); end
      if (got.size() != exp.size()) begin n_fail++;
         $display("FAIL rstmid_count got %0d want %0d",
                  got.size(), exp.size()); end
      foreach (exp[i]) begin
         n_checks++;
         if (got[i] !== exp[i]) begin n_fail++;
            $display("FAIL rstmid_byte%0d got %h want %h",
                     i, got[i], exp[i]); end
      end
   endtask

   task automatic test_padding();
      int  dn;
      bit  to;
      logic [15:0] w;
      for (int r = 0; r < 2; r++) begin
         mem_b[0] = (r == 0) ? 12'hABC : 12'($urandom);
         w = {4'h0, mem_b[0]};
         exp.delete();
         exp.push_back(w[15:8]);
         exp.push_back(w[7:0]);
`ifdef VERIFLA_READOUT_CHECKSUM_EN
         exp.push_back(w[15:8] ^ w[7:0]);
`endif
         got.delete();
         dn = 0;
         to = 1'b1;
         @(negedge clk);
         b_if.sc_run = 1'b1;
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (b_if.ack_sc_run === 1'b1) b_if.sc_run = 1'b0;
            if (b_if.sc_done === 1'b1) begin dn++; to = 1'b0; break; end
            b_if.tx_ready = ($urandom_range(99) < 50);
            if (b_if.tx_valid && b_if.tx_ready) got.push_back(b_if.tx_data);
         end
         n_checks += 2;
         if (to || dn != 1) begin n_fail++;
            $display("FAIL pad%0d_done got %0d want 1", r, dn); end
         if (got.size() != exp.size()) begin n_fail++;
            $display("FAIL pad%0d_count got %0d want %0d",
                     r, got.size(), exp.size()); end
         foreach (exp[i]) begin
            n_checks++;
            if (got[i] !== exp[i]) begin n_fail++;
               $display("FAIL pad%0d_byte%0d got %h want %h",
                        r, i, got[i], exp[i]); end
         end
      end
   endtask

   initial begin
      a_if.sc_run = 1'b0;
      a_if.tx_ready = 1'b0;
      b_if.sc_run = 1'b0;
      b_if.tx_ready = 1'b0;
      for (int a = 0; a < 256; a++) begin
         mem_a[a] = 24'($urandom);
         mem_b[a] = 12'($urandom);
      end
      test_reset();
      test_basic();
      test_backpressure();
      test_sc_run_hold();
      test_reset_mid();
      test_padding();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
